adder_result_accumulator: RTL and testbench
===========================================

Name: adder_result_accumulator

Overview:
- Downstream consumer of the 2-bit mux/adder stage.
- Samples the adder sum {S1,S0} under a valid/ready handshake and accumulates NUM_SAMPLES results into a wrapping ACC_W-bit register.
- Raises done when the run completes; flags overflow on wrap.
- Turns the combinational adder into a multi-operand summing datapath, checkable on board LEDs.

Parameters:
- ACC_W, 8, accumulator width in bits; must be >= 2.
- NUM_SAMPLES, 4, results accepted per run; must be >= 1.
- CNT_W, 3, sample counter width; must satisfy 2^CNT_W > NUM_SAMPLES.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- S0  input  1  adder sum bit 0, from the upstream stage.
- S1  input  1  adder sum bit 1, from the upstream stage.
- in_valid  input  1  upstream asserts when S1:S0 holds a result to consume.
- in_ready  output  1  block can accept a result this cycle.
- start  input  1  begin a new run (single-cycle pulse or level).
- clear  input  1  synchronous abort; returns to IDLE with all outputs cleared.
- acc  output  ACC_W  running sum.
- count  output  CNT_W  results accepted in the current run.
- done  output  1  run complete; acc is final.
- overflow  output  1  sticky; acc wrapped at least once this run.

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-low (rst_n). While rst_n=0: state=IDLE, acc=0, count=0, done=0, overflow=0, in_ready=0. Release takes effect on the next rising edge.
- Three-state FSM: IDLE, ACCUM, DONE.
- in_ready=1 only in ACCUM. It is decoded from the registered state, so it has no combinational path from any input.
- done=1 only in DONE.
- IDLE:
  - start=1 -> ACCUM; acc, count and overflow cleared to 0.
  - S0, S1 and in_valid are ignored.
- ACCUM, on a cycle with in_valid=1:
  - Accept: acc <= (acc + {S1,S0}) mod 2^ACC_W, with the operand zero-extended to ACC_W.
  - count <= count+1.
  - If the addition carries out of bit ACC_W-1, overflow <= 1. It stays set until the next start, clear or reset.
  - Latency: the updated acc and count are visible on the cycle after the accepting edge.
- ACCUM, on a cycle with in_valid=0: acc and count hold. Gaps of any length are allowed.
- Run completion: an accept made while count==NUM_SAMPLES-1 moves the FSM to DONE on the same edge. In the following cycle count==NUM_SAMPLES, done=1 and in_ready=0.
- start while in ACCUM is ignored; the run continues.
- DONE:
  - acc, count, overflow and done hold indefinitely.
  - in_valid is ignored.
  - start=1 -> ACCUM with acc, count and overflow cleared; done drops the next cycle.
- clear=1 in any state:
  - Next state is IDLE; acc=0, count=0, overflow=0, done=0.
  - clear has priority over start and over a simultaneous accept; that sample is discarded.
- Reset mid-run: asynchronous return to the reset values above; the partial sum is lost.
- Upstream contract: S1:S0 must be stable whenever in_valid=1. Values when in_valid=0 are don't-care.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and S1:S0=3 -> acc=0, count=0, done=0, overflow=0, in_ready=0. After release, with no start, acc stays 0.
- Basic run (defaults): pulse start, then four cycles of in_valid=1 with S1:S0=1,2,3,1 -> acc=1,3,6,7. done=1 and count=4 one cycle after the 4th accept; overflow=0; in_ready=0 in DONE.
- Gaps, and ignored start (defaults): start, then S=2 valid, 3 idle cycles, S=2 valid, start pulsed mid-run (ignored), S=2 valid, S=2 valid -> acc=8, done=1. count holds at 1 throughout the idle cycles.
- Overflow (ACC_W=4, NUM_SAMPLES=6): six accepts of S1:S0=3 -> acc=2 (18 mod 16). overflow first rises after the 6th accept and is still 1 in DONE. A new start clears acc and overflow to 0.
- Clear priority (defaults): start, accept S=3, then a cycle with clear=1, start=1 and in_valid=1 with S=3 -> next cycle IDLE, acc=0, count=0, in_ready=0.
- Async reset mid-run: after two accepts (acc=4), drop rst_n between clock edges -> acc=0 and state IDLE immediately, without waiting for clk.

Source files
------------

// File: rtl/adder_result_accumulator.sv
// Accumulates NUM_SAMPLES two-bit adder results under a valid/ready handshake
// into a wrapping ACC_W-bit sum, with a done flag and a sticky overflow flag.
//
// state | meaning
// IDLE  | waiting for start; in_ready low
// ACCUM | accepting results; in_ready high
// DONE  | run complete; acc/count/overflow frozen
module adder_result_accumulator #(
  parameter int ACC_W       = 8,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S0,
  input  logic             S1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             start,
  input  logic             clear,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             last;
  logic [ACC_W:0]   sum;

  assign accept = (state_q == ACCUM) && in_valid;
  assign last   = (count_q == CNT_W'(NUM_SAMPLES - 1));
  // The extra top bit of sum is the carry out of the accumulator.
  assign sum    = {1'b0, acc_q} + {{(ACC_W-1){1'b0}}, S1, S0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = ACCUM;
        ACCUM:   if (accept && last) state_d = DONE;
        DONE:    if (start) state_d = ACCUM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready = (state_q == ACCUM);
    done     = (state_q == DONE);
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (start && (state_q != ACCUM)) begin
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      acc_d   = sum[ACC_W-1:0];
      count_d = count_q + 1'b1;
      ovf_d   = ovf_q | sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign acc      = acc_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Scoreboard bench: stimulus pushes hand-computed results per accepted sample,
// monitors pop and compare after each accepting edge.
module tb_adder_result_accumulator;

  typedef struct {
    logic [7:0] acc;
    logic [2:0] cnt;
    logic       done;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default-parameter instance
  logic       st, clr, iv;
  logic [1:0] s;
  logic       rdy;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic       dn, ovf;

  // ACC_W=4, NUM_SAMPLES=6 instance
  logic       st2, clr2, iv2;
  logic [1:0] s2;
  logic       rdy2;
  logic [3:0] acc2;
  logic [2:0] cnt2;
  logic       dn2, ovf2;

  adder_result_accumulator dut (
    .clk(clk), .rst_n(rst_n), .S0(s[0]), .S1(s[1]), .in_valid(iv),
    .in_ready(rdy), .start(st), .clear(clr), .acc(acc), .count(cnt),
    .done(dn), .overflow(ovf)
  );

  adder_result_accumulator #(.ACC_W(4), .NUM_SAMPLES(6), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .S0(s2[0]), .S1(s2[1]), .in_valid(iv2),
    .in_ready(rdy2), .start(st2), .clear(clr2), .acc(acc2), .count(cnt2),
    .done(dn2), .overflow(ovf2)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t q1[$];
  exp_t q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int a, input int c, input bit d, input bit o);
    exp_t e;
    e.acc  = 8'(a);
    e.cnt  = 3'(c);
    e.done = d;
    e.ovf  = o;
    return e;
  endfunction

  logic fire1, fire2;

  always @(posedge clk) begin
    fire1 = iv && rdy && !clr && rst_n;
    #1;
    if (fire1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_accept", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_acc", 32'(acc), 32'(e.acc));
        chk("dut1_count", 32'(cnt), 32'(e.cnt));
        chk("dut1_done", 32'(dn), 32'(e.done));
        chk("dut1_overflow", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  always @(posedge clk) begin
    fire2 = iv2 && rdy2 && !clr2 && rst_n;
    #1;
    if (fire2) begin
      if (q2.size() == 0) begin
        chk("dut2_unexpected_accept", 1, 0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_acc", 32'(acc2), 32'(e.acc));
        chk("dut2_count", 32'(cnt2), 32'(e.cnt));
        chk("dut2_done", 32'(dn2), 32'(e.done));
        chk("dut2_overflow", 32'(ovf2), 32'(e.ovf));
      end
    end
  end

  // one negedge-aligned cycle on dut1
  task automatic cyc1(input logic vst, input logic vclr, input logic viv, input logic [1:0] vs);
    @(negedge clk);
    st = vst; clr = vclr; iv = viv; s = vs;
  endtask

  task automatic cyc2(input logic vst, input logic viv, input logic [1:0] vs);
    @(negedge clk);
    st2 = vst; iv2 = viv; s2 = vs;
  endtask

  initial begin
    rst_n = 1'b0;
    st = 0; clr = 0; iv = 1; s = 2'd3;
    st2 = 0; clr2 = 0; iv2 = 1; s2 = 2'd3;

    // reset
    repeat (2) @(negedge clk);
    chk("rst_acc", 32'(acc), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_done", 32'(dn), 0);
    chk("rst_overflow", 32'(ovf), 0);
    chk("rst_in_ready", 32'(rdy), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_acc_no_start", 32'(acc), 0);
    chk("idle_in_ready", 32'(rdy), 0);
    iv2 = 0;

    // basic run
    cyc1(1, 0, 0, 0);
    q1.push_back(mk(1, 1, 0, 0)); cyc1(0, 0, 1, 1);
    q1.push_back(mk(3, 2, 0, 0)); cyc1(0, 0, 1, 2);
    q1.push_back(mk(6, 3, 0, 0)); cyc1(0, 0, 1, 3);
    q1.push_back(mk(7, 4, 1, 0)); cyc1(0, 0, 1, 1);
    cyc1(0, 0, 1, 3);
    chk("basic_done", 32'(dn), 1);
    chk("basic_count", 32'(cnt), 4);
    chk("basic_in_ready", 32'(rdy), 0);
    chk("basic_overflow", 32'(ovf), 0);
    cyc1(0, 0, 0, 0);
    chk("done_hold_acc", 32'(acc), 7);

    // gaps and ignored start
    cyc1(1, 0, 0, 0);
    cyc1(0, 0, 0, 0);
    chk("restart_done_drop", 32'(dn), 0);
    chk("restart_acc", 32'(acc), 0);
    chk("restart_count", 32'(cnt), 0);
    q1.push_back(mk(2, 1, 0, 0)); cyc1(0, 0, 1, 2);
    for (int i = 0; i < 3; i++) begin
      cyc1(0, 0, 0, 1);
      chk("gap_count_hold", 32'(cnt), 1);
    end
    q1.push_back(mk(4, 2, 0, 0)); cyc1(0, 0, 1, 2);
    q1.push_back(mk(6, 3, 0, 0)); cyc1(1, 0, 1, 2);
    q1.push_back(mk(8, 4, 1, 0)); cyc1(0, 0, 1, 2);
    cyc1(0, 0, 0, 0);
    chk("gaps_acc", 32'(acc), 8);
    chk("gaps_done", 32'(dn), 1);

    // clear priority over start and accept
    cyc1(1, 0, 0, 0);
    q1.push_back(mk(3, 1, 0, 0)); cyc1(0, 0, 1, 3);
    cyc1(1, 1, 1, 3);
    cyc1(0, 0, 0, 0);
    chk("clear_acc", 32'(acc), 0);
    chk("clear_count", 32'(cnt), 0);
    chk("clear_in_ready", 32'(rdy), 0);
    chk("clear_done", 32'(dn), 0);
    @(negedge clk);
    chk("clear_stays_idle", 32'(rdy), 0);

    // overflow on the narrow instance
    cyc2(1, 0, 0);
    q2.push_back(mk(3, 1, 0, 0));  cyc2(0, 1, 3);
    q2.push_back(mk(6, 2, 0, 0));  cyc2(0, 1, 3);
    q2.push_back(mk(9, 3, 0, 0));  cyc2(0, 1, 3);
    q2.push_back(mk(12, 4, 0, 0)); cyc2(0, 1, 3);
    q2.push_back(mk(15, 5, 0, 0)); cyc2(0, 1, 3);
    q2.push_back(mk(2, 6, 1, 1));  cyc2(0, 1, 3);
    cyc2(0, 0, 0);
    cyc2(0, 0, 0);
    chk("ovf_sticky_done", 32'(ovf2), 1);
    chk("ovf_acc_hold", 32'(acc2), 2);
    chk("ovf_in_ready", 32'(rdy2), 0);
    cyc2(1, 0, 0);
    cyc2(0, 0, 0);
    chk("ovf_restart_acc", 32'(acc2), 0);
    chk("ovf_restart_flag", 32'(ovf2), 0);
    chk("ovf_restart_ready", 32'(rdy2), 1);

    // async reset mid-run
    cyc1(1, 0, 0, 0);
    q1.push_back(mk(2, 1, 0, 0)); cyc1(0, 0, 1, 2);
    q1.push_back(mk(4, 2, 0, 0)); cyc1(0, 0, 1, 2);
    cyc1(0, 0, 0, 0);
    chk("pre_reset_acc", 32'(acc), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_acc", 32'(acc), 0);
    chk("async_rst_count", 32'(cnt), 0);
    chk("async_rst_in_ready", 32'(rdy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", 32'(rdy), 0);

    chk("dut1_queue_drained", 32'(q1.size()), 0);
    chk("dut2_queue_drained", 32'(q2.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
